frame_ctrl: RTL and testbench

Coefficient update scheduler for the pole/zero filter datapath. Accepts per-coefficient writes from the control side into an 8-entry shadow bank (4 zeros, 4 poles). On a commit request it waits for the next audio frame boundary, derived by counting sample ticks, then issues a single-cycle `frame_done` so the downstream frame register captures all eight coefficients atomically. This prevents coefficient tearing mid-frame.

---
 rtl/frame_ctrl_if.sv | 21 ++
 rtl/frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_ctrl_if.sv
// Coefficient write/commit handshake between the control side (master)
// and the frame_ctrl coefficient scheduler (slave).
interface frame_ctrl_if #(
   parameter int unsigned CW = 32
);
   logic          coef_valid;
   logic          coef_ready;
   logic [2:0]    coef_addr;
   logic [CW-1:0] coef_data;
   logic          coef_commit;

   modport master (
      output coef_valid, coef_addr, coef_data, coef_commit,
      input  coef_ready
   );

   modport slave (
      input  coef_valid, coef_addr, coef_data, coef_commit,
      output coef_ready
   );
endinterface

// File: rtl/frame_ctrl.sv
// Coefficient update scheduler: collects zero/pole writes in a shadow bank and
// releases them atomically with a one-cycle frame_done at the next frame boundary.
module frame_ctrl #(
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned CW        = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   frame_ctrl_if.slave   coef,
   input  logic          sample_tick,
   input  logic          err_clr,
   output logic          busy,
   output logic          frame_done,
   output logic          commit_ack,
   output logic          wr_drop,
   output logic [CW-1:0] zero_in_0,
   output logic [CW-1:0] zero_in_1,
   output logic [CW-1:0] zero_in_2,
   output logic [CW-1:0] zero_in_3,
   output logic [CW-1:0] pole_in_0,
   output logic [CW-1:0] pole_in_1,
   output logic [CW-1:0] pole_in_2,
   output logic [CW-1:0] pole_in_3,
   output logic [15:0]   frame_idx
);

   localparam int unsigned       CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_SWAP
   } state_e;

   state_e               state_q;
   logic                 coef_ready_q;
   logic                 busy_q;
   logic                 frame_done_q;
   logic                 commit_ack_q;
   logic                 wr_drop_q,   wr_drop_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic [15:0]          frame_idx_q, frame_idx_d;
   logic [7:0][CW-1:0]   shadow_q,    shadow_d;

   logic boundary;
   logic wr_accept;

   assign boundary  = sample_tick && (cnt_q == CNT_LAST);
   // coef_ready_q is high exactly in IDLE, so it doubles as the write-enable.
   assign wr_accept = coef.coef_valid && coef_ready_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      shadow_d    = shadow_q;
      cnt_d       = cnt_q;
      frame_idx_d = frame_idx_q;
      wr_drop_d   = wr_drop_q;

      if (wr_accept) shadow_d[coef.coef_addr] = coef.coef_data;

      if (sample_tick) cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
      if (boundary)    frame_idx_d = frame_idx_q + 16'd1;

      // A dropped write in the same cycle as err_clr keeps the flag set.
      if (coef.coef_valid && !coef_ready_q) wr_drop_d = 1'b1;
      else if (err_clr)                     wr_drop_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the shadow bank is reset too; a reset mid-commit must hand zeros downstream.
         shadow_q    <= '0;
         cnt_q       <= '0;
         frame_idx_q <= '0;
         wr_drop_q   <= 1'b0;
      end else begin
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         frame_idx_q <= frame_idx_d;
         wr_drop_q   <= wr_drop_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         coef_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         commit_ack_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
         frame_done_q <= 1'b0;
         commit_ack_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (coef.coef_commit) begin
                  state_q      <= ST_PENDING;
                  coef_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (boundary) begin
                  state_q      <= ST_SWAP;
                  frame_done_q <= 1'b1;
                  commit_ack_q <= 1'b1;
               end
            end
            ST_SWAP: begin
               state_q      <= ST_IDLE;
               coef_ready_q <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q      <= ST_IDLE;
               coef_ready_q <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign coef.coef_ready = coef_ready_q;
   assign busy            = busy_q;
   assign frame_done      = frame_done_q;
   assign commit_ack      = commit_ack_q;
   assign wr_drop         = wr_drop_q;
   assign frame_idx       = frame_idx_q;

   assign zero_in_0 = shadow_q[0];
   assign zero_in_1 = shadow_q[1];
   assign zero_in_2 = shadow_q[2];
   assign zero_in_3 = shadow_q[3];
   assign pole_in_0 = shadow_q[4];
   assign pole_in_1 = shadow_q[5];
   assign pole_in_2 = shadow_q[6];
   assign pole_in_3 = shadow_q[7];

endmodule

// File: tb/tb_frame_ctrl.sv
// Bench for frame_ctrl: directed vector table, hand-written reset sequence,
// then random traffic compared against a frame-arithmetic reference model.
module tb_frame_ctrl;

   localparam int unsigned FL = 4;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sample_tick;
   logic          err_clr;
   logic          busy, frame_done, commit_ack, wr_drop;
   logic [CW-1:0] zero_in_0, zero_in_1, zero_in_2, zero_in_3;
   logic [CW-1:0] pole_in_0, pole_in_1, pole_in_2, pole_in_3;
   logic [15:0]   frame_idx;

   frame_ctrl_if #(.CW(CW)) cif ();

   frame_ctrl #(.FRAME_LEN(FL), .CW(CW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .coef        (cif),
      .sample_tick (sample_tick),
      .err_clr     (err_clr),
      .busy        (busy),
      .frame_done  (frame_done),
      .commit_ack  (commit_ack),
      .wr_drop     (wr_drop),
      .zero_in_0   (zero_in_0),
      .zero_in_1   (zero_in_1),
      .zero_in_2   (zero_in_2),
      .zero_in_3   (zero_in_3),
      .pole_in_0   (pole_in_0),
      .pole_in_1   (pole_in_1),
      .pole_in_2   (pole_in_2),
      .pole_in_3   (pole_in_3),
      .frame_idx   (frame_idx)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] shadow_out(input int i);
      case (i)
         0:       return zero_in_0;
         1:       return zero_in_1;
         2:       return zero_in_2;
         3:       return zero_in_3;
         4:       return pole_in_0;
         5:       return pole_in_1;
         6:       return pole_in_2;
         default: return pole_in_3;
      endcase
   endfunction

   task automatic drive(input logic tick, input logic valid, input logic [2:0] addr,
                        input logic [CW-1:0] data, input logic commit, input logic clr);
      sample_tick     = tick;
      cif.coef_valid  = valid;
      cif.coef_addr   = addr;
      cif.coef_data   = data;
      cif.coef_commit = commit;
      err_clr         = clr;
   endtask

   typedef struct {
      logic          tick, valid;
      logic [2:0]    addr;
      logic [CW-1:0] data;
      logic          commit, clr;
      logic          e_ready, e_busy, e_done, e_drop;
      logic [15:0]   e_idx;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic tick, input logic valid, input logic [2:0] addr,
                      input logic [CW-1:0] data, input logic commit, input logic clr,
                      input logic er, input logic eb, input logic ed, input logic edrop,
                      input logic [15:0] eidx);
      vec_t v;
      v.tick = tick; v.valid = valid; v.addr = addr; v.data = data;
      v.commit = commit; v.clr = clr;
      v.e_ready = er; v.e_busy = eb; v.e_done = ed; v.e_drop = edrop; v.e_idx = eidx;
      vecs.push_back(v);
   endtask

   // Reference model state: total ticks since reset give counter and frame index.
   int unsigned   m_ticks;
   logic [CW-1:0] m_shadow [8];
   bit            m_pending, m_swap, m_drop;

   task automatic model_reset();
      m_ticks = 0; m_pending = 0; m_swap = 0; m_drop = 0;
      for (int i = 0; i < 8; i++) m_shadow[i] = '0;
   endtask

   task automatic model_step(input logic tick, input logic valid, input logic [2:0] addr,
                             input logic [CW-1:0] data, input logic commit, input logic clr);
      bit rdy, bnd, nxt_pending;
      rdy = !(m_pending || m_swap);
      bnd = tick && ((m_ticks % FL) == FL - 1);
      if (valid && rdy) m_shadow[addr] = data;
      if (valid && !rdy) m_drop = 1;
      else if (clr)      m_drop = 0;
      nxt_pending = (m_pending && !bnd) || (rdy && commit);
      m_swap      = m_pending && bnd;
      m_pending   = nxt_pending;
      m_ticks     = m_ticks + (tick ? 1 : 0);
   endtask

   logic [CW-1:0] exp_shadow [8];

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, '0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      check("rst_ready", cif.coef_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_ack", commit_ack, 0);
      check("rst_drop", wr_drop, 0);
      check("rst_idx", frame_idx, 0);

      // Free-running ticks, shadow writes, commit at cnt=1, drops and err_clr.
      for (int k = 1; k <= 8; k++) add(1, 0, 0, '0, 0, 0, 1, 0, 0, 0, 16'(k / 4));
      for (int i = 0; i < 8; i++) begin
         exp_shadow[i] = 32'h1111_1111 * (i + 1);
         add(0, 1, 3'(i), exp_shadow[i], 0, 0, 1, 0, 0, 0, 2);
      end
      add(1, 0, 0, '0,           0, 0, 1, 0, 0, 0, 2);
      add(0, 0, 0, '0,           1, 0, 0, 1, 0, 0, 2);
      add(1, 0, 0, '0,           0, 0, 0, 1, 0, 0, 2);
      add(0, 1, 2, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 2);
      add(0, 0, 0, '0,           0, 1, 0, 1, 0, 0, 2);
      add(0, 1, 2, 32'hDEADBEEF, 0, 1, 0, 1, 0, 1, 2);
      add(0, 0, 0, '0,           0, 1, 0, 1, 0, 0, 2);
      add(1, 0, 0, '0,           0, 0, 0, 1, 0, 0, 2);
      add(1, 0, 0, '0,           0, 0, 0, 1, 1, 0, 3);
      add(0, 0, 0, '0,           0, 0, 1, 0, 0, 0, 3);
      // Commit on the boundary tick waits a whole frame.
      for (int k = 0; k < 3; k++) add(1, 0, 0, '0, 0, 0, 1, 0, 0, 0, 3);
      add(1, 0, 0, '0,           1, 0, 0, 1, 0, 0, 4);
      for (int k = 0; k < 3; k++) add(1, 0, 0, '0, 0, 0, 0, 1, 0, 0, 4);
      add(1, 0, 0, '0,           0, 0, 0, 1, 1, 0, 5);
      add(0, 0, 0, '0,           0, 0, 1, 0, 0, 0, 5);
      // Write + commit together, then repeated commits that must be ignored.
      add(0, 1, 5, 32'h42,       1, 0, 0, 1, 0, 0, 5);
      add(0, 0, 0, '0,           1, 0, 0, 1, 0, 0, 5);
      for (int k = 0; k < 3; k++) add(1, 0, 0, '0, 0, 0, 0, 1, 0, 0, 5);
      add(1, 0, 0, '0,           0, 0, 0, 1, 1, 0, 6);
      add(0, 0, 0, '0,           1, 0, 1, 0, 0, 0, 6);
      add(0, 0, 0, '0,           0, 0, 1, 0, 0, 0, 6);
      for (int k = 0; k < 3; k++) add(1, 0, 0, '0, 0, 0, 1, 0, 0, 0, 6);
      add(1, 0, 0, '0,           0, 0, 1, 0, 0, 0, 7);
      exp_shadow[5] = 32'h42;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].tick, vecs[i].valid, vecs[i].addr, vecs[i].data,
               vecs[i].commit, vecs[i].clr);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_ready", i), cif.coef_ready, vecs[i].e_ready);
         check($sformatf("v%0d_busy", i),  busy,           vecs[i].e_busy);
         check($sformatf("v%0d_done", i),  frame_done,     vecs[i].e_done);
         check($sformatf("v%0d_ack", i),   commit_ack,     vecs[i].e_done);
         check($sformatf("v%0d_drop", i),  wr_drop,        vecs[i].e_drop);
         check($sformatf("v%0d_idx", i),   frame_idx,      vecs[i].e_idx);
      end
      drive(0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) check($sformatf("shadow%0d", i), shadow_out(i), exp_shadow[i]);

      // Reset while PENDING aborts the swap and zeroes the bank.
      drive(0, 0, 0, '0, 1, 0);
      @(posedge clk); #1;
      check("pend_busy", busy, 1);
      drive(1, 0, 0, '0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, '0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_ready", cif.coef_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_idx", frame_idx, 0);
      for (int i = 0; i < 8; i++) check($sformatf("arst_shadow%0d", i), shadow_out(i), 0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 0, 0, '0, 0, 0);
      for (int k = 0; k < FL + 1; k++) begin
         @(posedge clk); #1;
         check($sformatf("arst_nodone%0d", k), frame_done, 0);
      end
      drive(0, 0, 0, '0, 0, 0);
      check("arst_idx_after", frame_idx, 1);
      check("arst_ready_after", cif.coef_ready, 1);

      // Random traffic against the reference model.
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         logic          r_tick, r_valid, r_commit, r_clr;
         logic [2:0]    r_addr;
         logic [CW-1:0] r_data;
         r_tick   = 1'($urandom_range(0, 1));
         r_valid  = ($urandom_range(0, 2) == 0);
         r_commit = ($urandom_range(0, 7) == 0);
         r_clr    = ($urandom_range(0, 5) == 0);
         r_addr   = 3'($urandom_range(0, 7));
         r_data   = $urandom;
         drive(r_tick, r_valid, r_addr, r_data, r_commit, r_clr);
         @(posedge clk); #1;
         model_step(r_tick, r_valid, r_addr, r_data, r_commit, r_clr);
         check("rnd_ready", cif.coef_ready, !(m_pending || m_swap));
         check("rnd_busy",  busy,           m_pending || m_swap);
         check("rnd_done",  frame_done,     m_swap);
         check("rnd_ack",   commit_ack,     m_swap);
         check("rnd_drop",  wr_drop,        m_drop);
         check("rnd_idx",   frame_idx,      16'((m_ticks / FL) % 65536));
         for (int i = 0; i < 8; i++) check($sformatf("rnd_shadow%0d", i), shadow_out(i), m_shadow[i]);
      end
      drive(0, 0, 0, '0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
